// File: rtl/ptw_req_sched.sv
// ptw_req_sched: round-robin scheduler of N TLB page-table-walk requests onto one walker port.
// Optional walk timeout enabled by defining PTW_SCHED_TIMEOUT_EN.
module ptw_req_sched #(
  parameter int N = 2,
  parameter int ADDR_W = 27,
  parameter int PPN_W = 20,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        io_req_valid,
  output logic [N-1:0]        io_req_ready,
  input  logic [N*ADDR_W-1:0] io_req_addr,
  input  logic [2*N-1:0]      io_req_prv,
  input  logic [N-1:0]        io_req_store,
  input  logic [N-1:0]        io_req_fetch,
  output logic                io_walk_valid,
  input  logic                io_walk_ready,
  output logic [ADDR_W-1:0]   io_walk_addr,
  output logic [1:0]          io_walk_prv,
  output logic                io_walk_store,
  output logic                io_walk_fetch,
  input  logic                io_walk_resp_valid,
  input  logic [PPN_W-1:0]    io_walk_resp_ppn,
  input  logic                io_walk_resp_fault,
  output logic [N-1:0]        io_resp_valid,
  output logic [PPN_W-1:0]    io_resp_ppn,
  output logic                io_resp_fault,
  output logic                io_busy,
  output logic [$clog2(N)-1:0] io_owner,
  output logic                io_timeout
);
  localparam int OW = $clog2(N);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [OW-1:0] last_grant, winner, idx;
  logic any_valid;
`ifdef PTW_SCHED_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES >= 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt;
  logic timeout_hit;
`endif
  // Scan downward so the nearest index after last_grant is the final writer.
  always_comb begin
    winner = last_grant;
    any_valid = 1'b0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = OW'((int'(last_grant) + k) % N);
      if (io_req_valid[idx]) begin
        winner = idx;
        any_valid = 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    io_req_ready = '0;
    io_walk_valid = 1'b0;
    io_resp_valid = '0;
`ifdef PTW_SCHED_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    unique case (state)
      IDLE: if (any_valid) begin
        io_req_ready[winner] = 1'b1;
        state_nx = ISSUE;
      end
      ISSUE: begin
        io_walk_valid = 1'b1;
        state_nx = io_walk_ready ? WAIT : ISSUE;
      end
      WAIT: begin
        if (io_walk_resp_valid) state_nx = RESP;
`ifdef PTW_SCHED_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYCLES)) begin
          timeout_hit = 1'b1;
          state_nx = RESP;
        end
`endif
      end
      RESP: begin
        io_resp_valid[io_owner] = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      io_walk_addr <= '0;
      io_walk_prv <= '0;
      io_walk_store <= 1'b0;
      io_walk_fetch <= 1'b0;
      io_resp_ppn <= '0;
      io_resp_fault <= 1'b0;
      io_owner <= '0;
      last_grant <= OW'(N - 1);
    end else begin
      if (state == IDLE && any_valid) begin
        io_walk_addr <= io_req_addr[winner*ADDR_W +: ADDR_W];
        io_walk_prv <= io_req_prv[winner*2 +: 2];
        io_walk_store <= io_req_store[winner];
        io_walk_fetch <= io_req_fetch[winner];
        io_owner <= winner;
      end
      if (state == WAIT && io_walk_resp_valid) begin
        io_resp_ppn <= io_walk_resp_ppn;
        io_resp_fault <= io_walk_resp_fault;
      end
`ifdef PTW_SCHED_TIMEOUT_EN
      if (timeout_hit) begin
        io_resp_ppn <= '0;
        io_resp_fault <= 1'b1;
      end
`endif
      if (state == RESP) last_grant <= io_owner;
    end
  end
`ifdef PTW_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      io_timeout <= 1'b0;
    end else begin
      cnt <= (state == ISSUE) ? '0 : (state == WAIT) ? cnt + 1'b1 : cnt;
      io_timeout <= timeout_hit;
    end
  end
`else
  assign io_timeout = 1'b0;
`endif
  assign io_busy = state != IDLE;
endmodule

// File: tb/tb_ptw_req_sched.sv
// tb_ptw_req_sched: directed self-checking bench for ptw_req_sched (N=2, TIMEOUT_CYCLES=4).
module tb_ptw_req_sched;
  localparam int N = 2, AW = 27, PW = 20, TO = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, req_store = '0, req_fetch = '0, resp_valid;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [2*N-1:0] req_prv = '0;
  logic walk_valid, walk_ready = 1'b0, walk_store, walk_fetch;
  logic [AW-1:0] walk_addr;
  logic [1:0] walk_prv;
  logic wr_valid = 1'b0, wr_fault = 1'b0, resp_fault, busy, timeout;
  logic [PW-1:0] wr_ppn = '0, resp_ppn;
  logic [0:0] owner;
  int checks = 0, errors = 0;

  ptw_req_sched #(.N(N), .ADDR_W(AW), .PPN_W(PW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .io_req_valid(req_valid), .io_req_ready(req_ready), .io_req_addr({a1, a0}),
    .io_req_prv(req_prv), .io_req_store(req_store), .io_req_fetch(req_fetch),
    .io_walk_valid(walk_valid), .io_walk_ready(walk_ready), .io_walk_addr(walk_addr),
    .io_walk_prv(walk_prv), .io_walk_store(walk_store), .io_walk_fetch(walk_fetch),
    .io_walk_resp_valid(wr_valid), .io_walk_resp_ppn(wr_ppn), .io_walk_resp_fault(wr_fault),
    .io_resp_valid(resp_valid), .io_resp_ppn(resp_ppn), .io_resp_fault(resp_fault),
    .io_busy(busy), .io_owner(owner), .io_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step;
    step;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (walk_valid !== 1'b0) begin errors++; $display("FAIL reset_walk_valid: got %b exp 0", walk_valid); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b exp 00", req_ready); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b exp 00", resp_valid); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %0d exp 0", owner); end
    checks++; if (walk_addr !== '0 || resp_ppn !== '0 || resp_fault !== 1'b0) begin errors++; $display("FAIL reset_latches: addr %h ppn %h fault %b exp 0", walk_addr, resp_ppn, resp_fault); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b exp 0", timeout); end
  endtask

  task automatic test_single;
    req_valid = 2'b10; a1 = 27'h1234567; req_prv = 4'b1100; req_store = 2'b10; walk_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL single_ready: got %b exp 10", req_ready); end
    step;
    req_valid = 2'b00;
    checks++; if (walk_valid !== 1'b1 || walk_addr !== 27'h1234567) begin errors++; $display("FAIL single_walk: valid %b addr %h exp 1 1234567", walk_valid, walk_addr); end
    checks++; if (walk_prv !== 2'b11 || walk_store !== 1'b1 || walk_fetch !== 1'b0) begin errors++; $display("FAIL single_fields: prv %b st %b fe %b exp 11 1 0", walk_prv, walk_store, walk_fetch); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL single_ready_issue: got %b exp 00", req_ready); end
    step;
    checks++; if (walk_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_wait: walk_valid %b busy %b exp 0 1", walk_valid, busy); end
    step;
    wr_valid = 1'b1; wr_ppn = 20'hABCDE;
    step;
    wr_valid = 1'b0;
    checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL single_resp_valid: got %b exp 10", resp_valid); end
    checks++; if (resp_ppn !== 20'hABCDE || resp_fault !== 1'b0 || owner !== 1'b1) begin errors++; $display("FAIL single_resp: ppn %h fault %b owner %0d exp abcde 0 1", resp_ppn, resp_fault, owner); end
    step;
    checks++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL single_done: resp_valid %b busy %b exp 00 0", resp_valid, busy); end
    req_prv = '0; req_store = '0;
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_oh;
    reset = 1'b1;
    step;
    reset = 1'b0;
    req_valid = 2'b11; a0 = 27'h0000AAA; a1 = 27'h7FFFFFF; walk_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      exp_oh = (w % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL rr_ready%0d: got %b exp %b", w, req_ready, exp_oh); end
      step;
      checks++; if (walk_addr !== ((w % 2 == 0) ? 27'h0000AAA : 27'h7FFFFFF)) begin errors++; $display("FAIL rr_addr%0d: got %h", w, walk_addr); end
      step;
      wr_valid = 1'b1; wr_ppn = PW'(w + 1);
      step;
      wr_valid = 1'b0;
      if (w == 3) req_valid = 2'b00;
      checks++; if (resp_valid !== exp_oh || owner !== 1'(w % 2) || resp_ppn !== PW'(w + 1)) begin errors++; $display("FAIL rr_resp%0d: valid %b owner %0d ppn %h exp %b %0d %0d", w, resp_valid, owner, resp_ppn, exp_oh, w % 2, w + 1); end
      step;
    end
  endtask

  task automatic test_stall_fault;
    req_valid = 2'b01; a0 = 27'h0ABCDEF; walk_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_ready: got %b exp 01", req_ready); end
    step;
    req_valid = 2'b00; a0 = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (walk_valid !== 1'b1 || walk_addr !== 27'h0ABCDEF) begin errors++; $display("FAIL stall_hold%0d: valid %b addr %h exp 1 0abcdef", i, walk_valid, walk_addr); end
      step;
    end
    walk_ready = 1'b1; wr_valid = 1'b1; wr_ppn = 20'h11111;
    step;
    wr_valid = 1'b0;
    checks++; if (walk_valid !== 1'b0) begin errors++; $display("FAIL stall_accept: walk_valid %b exp 0", walk_valid); end
    step;
    checks++; if (busy !== 1'b1 || resp_valid !== 2'b00 || resp_ppn === 20'h11111) begin errors++; $display("FAIL stall_early_resp: busy %b resp_valid %b ppn %h", busy, resp_valid, resp_ppn); end
    wr_valid = 1'b1; wr_fault = 1'b1; wr_ppn = 20'h22222;
    step;
    wr_valid = 1'b0; wr_fault = 1'b0;
    checks++; if (resp_valid !== 2'b01 || resp_fault !== 1'b1 || resp_ppn !== 20'h22222) begin errors++; $display("FAIL fault_resp: valid %b fault %b ppn %h exp 01 1 22222", resp_valid, resp_fault, resp_ppn); end
    step;
    req_valid = 2'b10; a1 = 27'h0000123;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL after_fault_ready: got %b exp 10", req_ready); end
    step;
    req_valid = 2'b00;
    step;
    wr_valid = 1'b1; wr_ppn = 20'h33333;
    step;
    wr_valid = 1'b0;
    checks++; if (resp_valid !== 2'b10 || resp_fault !== 1'b0 || resp_ppn !== 20'h33333) begin errors++; $display("FAIL after_fault_resp: valid %b fault %b ppn %h exp 10 0 33333", resp_valid, resp_fault, resp_ppn); end
    step;
  endtask

  task automatic test_reset_in_wait;
    req_valid = 2'b01;
    step;
    req_valid = 2'b00;
    step;
    wr_valid = 1'b1; wr_ppn = 20'h55555;
    step;
    wr_valid = 1'b0;
    step;
    req_valid = 2'b10;
    step;
    req_valid = 2'b00;
    step;
    checks++; if (busy !== 1'b1 || owner !== 1'b1) begin errors++; $display("FAIL rst_wait_setup: busy %b owner %0d exp 1 1", busy, owner); end
    reset = 1'b1;
    step;
    reset = 1'b0; wr_valid = 1'b1; wr_ppn = 20'h44444;
    #1;
    checks++; if (busy !== 1'b0 || owner !== 1'b0 || resp_ppn !== '0) begin errors++; $display("FAIL rst_wait_state: busy %b owner %0d ppn %h exp 0 0 0", busy, owner, resp_ppn); end
    step;
    wr_valid = 1'b0;
    checks++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rst_wait_ignored: resp_valid %b busy %b exp 00 0", resp_valid, busy); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_wait_grant: got %b exp 01", req_ready); end
    step;
    req_valid = 2'b00;
    step;
    wr_valid = 1'b1;
    step;
    wr_valid = 1'b0;
    checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL rst_wait_resp: got %b exp 01", resp_valid); end
    step;
  endtask

  task automatic test_timeout;
    int n;
    req_valid = 2'b01; walk_ready = 1'b1;
    step;
    req_valid = 2'b00;
    step;
`ifdef PTW_SCHED_TIMEOUT_EN
    n = 0;
    while (timeout !== 1'b1 && n < 20) begin
      step;
      n++;
    end
    checks++; if (n !== TO + 1) begin errors++; $display("FAIL timeout_cycles: got %0d exp %0d", n, TO + 1); end
    checks++; if (resp_valid !== 2'b01 || resp_fault !== 1'b1 || resp_ppn !== '0) begin errors++; $display("FAIL timeout_resp: valid %b fault %b ppn %h exp 01 1 0", resp_valid, resp_fault, resp_ppn); end
    wr_valid = 1'b1; wr_ppn = 20'h77777;
    step;
    checks++; if (timeout !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_pulse: timeout %b busy %b exp 0 0", timeout, busy); end
    step;
    wr_valid = 1'b0;
    checks++; if (resp_valid !== 2'b00 || resp_ppn !== '0) begin errors++; $display("FAIL timeout_late: resp_valid %b ppn %h exp 00 0", resp_valid, resp_ppn); end
`else
    n = 0;
    repeat (20) step;
    checks++; if (busy !== 1'b1 || timeout !== 1'b0 || resp_valid !== 2'b00) begin errors++; $display("FAIL no_timeout: busy %b timeout %b resp_valid %b exp 1 0 00", busy, timeout, resp_valid); end
    reset = 1'b1;
    step;
    reset = 1'b0;
`endif
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_stall_fault;
    test_reset_in_wait;
    test_timeout;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ptw_req_sched.md
Name: ptw_req_sched

Overview:
- Schedules page-table-walk requests from N TLB requesters onto a single walker port, one walk outstanding at a time.
- Round-robin fair among requesters; latches the winning request, issues it, waits for the walker response, then routes it back to the originating requester.
- Sits between the I/D TLBs and the page-table walker.

Parameters:
- N, 2, number of requesters (2..8).
- ADDR_W, 27, virtual page number width.
- PPN_W, 20, physical page number width.
- TIMEOUT_CYCLES, 255, walk timeout limit. Used only with PTW_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- io_req_valid  in  N  per-requester request valid.
- io_req_ready  out  N  per-requester accept.
- io_req_addr  in  N*ADDR_W  flattened VPNs; requester i at [i*ADDR_W +: ADDR_W].
- io_req_prv  in  2*N  flattened privilege levels.
- io_req_store  in  N  store access.
- io_req_fetch  in  N  instruction fetch.
- io_walk_valid  out  1  walk request valid.
- io_walk_ready  in  1  walker accepts.
- io_walk_addr  out  ADDR_W  latched VPN.
- io_walk_prv  out  2  latched privilege.
- io_walk_store  out  1  latched store bit.
- io_walk_fetch  out  1  latched fetch bit.
- io_walk_resp_valid  in  1  walker response strobe.
- io_walk_resp_ppn  in  PPN_W  walker result.
- io_walk_resp_fault  in  1  walker page fault.
- io_resp_valid  out  N  one-hot response strobe to owner.
- io_resp_ppn  out  PPN_W  latched PPN, shared bus.
- io_resp_fault  out  1  latched fault, shared bus.
- io_busy  out  1  state != IDLE.
- io_owner  out  clog2(N)  index of current owner.
- io_timeout  out  1  one-cycle pulse on walk timeout.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset value is IDLE.
- Reset values:
  - io_req_ready, io_walk_valid, io_resp_valid, io_busy, io_timeout = 0.
  - io_owner = 0.
  - Latched addr/prv/store/fetch/ppn/fault = 0.
  - last_grant = N-1, so requester 0 wins first.
- IDLE:
  - Winner = first valid index scanning last_grant+1, last_grant+2, ... modulo N.
  - io_req_ready[winner]=1 combinationally in the same cycle. All other ready bits are 0.
  - On that cycle, latch the winner's fields and its index into owner, then go to ISSUE.
  - No valid requester: stay in IDLE.
- ISSUE:
  - io_walk_valid=1 with the latched fields.
  - Fields stay stable until io_walk_ready.
  - On valid&ready, go to WAIT.
- WAIT:
  - On io_walk_resp_valid, latch ppn and fault, then go to RESP.
- RESP:
  - io_resp_valid[owner]=1 for exactly one cycle.
  - last_grant <= owner, then go to IDLE.
- Latency: request accepted at cycle T; io_walk_valid at T+1; response to requester one cycle after io_walk_resp_valid.
- io_req_ready = 0 in every state except IDLE. New requests wait and stay valid.
- io_walk_resp_valid outside WAIT is ignored. This includes the same cycle as walk acceptance.
- io_owner, io_resp_ppn and io_resp_fault hold their values until the next latch.
- Reset asserted in any state: the next state is IDLE and all registers return to their reset values. An in-flight walk is abandoned; the walker is reset by the same signal.
- Next request may be accepted the cycle after RESP. Minimum turnaround is 4 cycles per walk.

Optional Feature:
- PTW_SCHED_TIMEOUT_EN defined:
  - An 8+-bit counter clears on entering WAIT and increments each WAIT cycle.
  - On count == TIMEOUT_CYCLES without a response, go to RESP with fault=1 and ppn=0, and pulse io_timeout for one cycle.
  - A response arriving in the same cycle as expiry wins; no timeout pulse.
  - A late response after timeout is ignored.
- Undefined: WAIT holds indefinitely, io_timeout is tied to 0, and no counter is instantiated.

Test Plan:
- Single requester: req1 valid, addr=0x1234567, walk_ready=1, resp 2 cycles later with ppn=0xABCDE -> ready[1] at T, walk_valid at T+1, resp_valid=2'b10 with ppn 0xABCDE, fault=0.
- Both requesters held valid continuously from reset -> grant order 0,1,0,1. io_owner matches each resp_valid.
- io_walk_ready low for 3 cycles in ISSUE -> walk_valid held with unchanged fields. Transition to WAIT only on the ready cycle.
- Fault response: resp_fault=1 -> io_resp_fault=1 to owner; the next walk proceeds normally.
- Reset pulsed in WAIT, then a walker response the cycle after -> response ignored, state IDLE, no resp_valid, requester 0 wins the next grant.
- With PTW_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=4, no walker response -> io_timeout pulse, resp fault=1, ppn=0. Without the macro, the scheduler stays busy indefinitely.
